// File: rtl/noc_src_arbiter_if.sv
// Injection-port bundle: NUM_REQ flattened source channels plus one NoC-facing port.
interface noc_src_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned N       = 16,
  parameter int unsigned NUM_VC  = 2,
  parameter int unsigned WIDTH   = 32
);
  localparam int unsigned N_ADDR_WIDTH  = $clog2(N);
  localparam int unsigned VC_ADDR_WIDTH = $clog2(NUM_VC);
  localparam int unsigned REQ_IDX_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ*WIDTH-1:0]         req_data_in;
  logic [NUM_REQ*N_ADDR_WIDTH-1:0]  req_dest_in;
  logic [NUM_REQ*VC_ADDR_WIDTH-1:0] req_vc_in;
  logic [NUM_REQ-1:0]               req_valid_in;
  logic [NUM_REQ-1:0]               req_ready_out;
  logic [WIDTH-1:0]                 o_data_out;
  logic [N_ADDR_WIDTH-1:0]          o_dest_out;
  logic [VC_ADDR_WIDTH-1:0]         o_vc_out;
  logic                             o_valid_out;
  logic                             o_ready_in;
  logic [REQ_IDX_WIDTH-1:0]         o_grant_id_out;
  logic [31:0]                      beat_count_out;

  // Arbiter side
  modport slave (
    input  req_data_in, req_dest_in, req_vc_in, req_valid_in, o_ready_in,
    output req_ready_out, o_data_out, o_dest_out, o_vc_out, o_valid_out,
           o_grant_id_out, beat_count_out
  );

  // Sources and NoC side
  modport master (
    output req_data_in, req_dest_in, req_vc_in, req_valid_in, o_ready_in,
    input  req_ready_out, o_data_out, o_dest_out, o_vc_out, o_valid_out,
           o_grant_id_out, beat_count_out
  );
endinterface

// File: rtl/noc_src_arbiter.sv
// Round-robin arbiter with bounded burst lock sharing one registered NoC injection port.
module noc_src_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned N         = 16,
  parameter int unsigned NUM_VC    = 2,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input logic              clk,
  input logic              rst_n,
  noc_src_arbiter_if.slave bus
);
  localparam int unsigned N_ADDR_WIDTH  = $clog2(N);
  localparam int unsigned VC_ADDR_WIDTH = $clog2(NUM_VC);
  localparam int unsigned REQ_IDX_WIDTH = $clog2(NUM_REQ);
  localparam int unsigned BURST_W       = $clog2(MAX_BURST + 1);

  // Output stage
  logic [WIDTH-1:0]         o_data_q,  o_data_d;
  logic [N_ADDR_WIDTH-1:0]  o_dest_q,  o_dest_d;
  logic [VC_ADDR_WIDTH-1:0] o_vc_q,    o_vc_d;
  logic                     o_valid_q, o_valid_d;
  logic [REQ_IDX_WIDTH-1:0] grant_q,   grant_d;
  logic [31:0]              beat_q,    beat_d;
  // Arbitration state
  logic [REQ_IDX_WIDTH-1:0] last_grant_q, last_grant_d;
  logic [REQ_IDX_WIDTH-1:0] owner_q,      owner_d;
  logic [BURST_W-1:0]       burst_q,      burst_d;
  logic                     lock_q,       lock_d;

  logic [WIDTH-1:0]         src_data [NUM_REQ];
  logic [N_ADDR_WIDTH-1:0]  src_dest [NUM_REQ];
  logic [VC_ADDR_WIDTH-1:0] src_vc   [NUM_REQ];

  logic [NUM_REQ-1:0]       valid;
  logic [NUM_REQ-1:0]       scan_mask;
  logic [NUM_REQ-1:0]       grant_onehot;
  logic [NUM_REQ-1:0]       req_ready_c;
  logic [REQ_IDX_WIDTH-1:0] winner;
  logic                     owner_valid;
  logic                     locked_win;
  logic                     load_en;
  logic                     src_xfer;
  logic                     noc_xfer;

  // Unflatten the per-source payload buses
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign src_data[k] = bus.req_data_in[k*WIDTH +: WIDTH];
    assign src_dest[k] = bus.req_dest_in[k*N_ADDR_WIDTH +: N_ADDR_WIDTH];
    assign src_vc[k]   = bus.req_vc_in[k*VC_ADDR_WIDTH +: VC_ADDR_WIDTH];
  end

  // First set bit of mask scanning last+1, last+2, ... modulo NUM_REQ
  function automatic logic [REQ_IDX_WIDTH-1:0] rr_pick(
    input logic [NUM_REQ-1:0]       mask,
    input logic [REQ_IDX_WIDTH-1:0] last
  );
    logic [REQ_IDX_WIDTH-1:0] pick;
    logic                     found;
    int unsigned              idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = (32'(last) + i) % NUM_REQ;
      if (!found && mask[REQ_IDX_WIDTH'(idx)]) begin
        pick  = REQ_IDX_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Winner selection: lock continuation, else round-robin with exhausted owner excluded
  always_comb begin
    valid        = bus.req_valid_in;
    owner_valid  = lock_q && valid[owner_q];
    locked_win   = owner_valid && (burst_q < BURST_W'(MAX_BURST));
    scan_mask    = valid;
    if (owner_valid && !locked_win) begin
      scan_mask[owner_q] = 1'b0;
    end
    if (locked_win) begin
      winner = owner_q;
    end else if (|scan_mask) begin
      winner = rr_pick(scan_mask, last_grant_q);
    end else begin
      winner = rr_pick(valid, last_grant_q);
    end
    grant_onehot         = '0;
    grant_onehot[winner] = 1'b1;
    load_en              = !o_valid_q || bus.o_ready_in;
    req_ready_c          = (rst_n && load_en && (|valid)) ? grant_onehot : '0;
    src_xfer             = |(valid & req_ready_c);
    noc_xfer             = o_valid_q && bus.o_ready_in;
  end

  // Next-state: output register load/drain, beat counter, lock bookkeeping
  always_comb begin
    o_data_d     = o_data_q;
    o_dest_d     = o_dest_q;
    o_vc_d       = o_vc_q;
    o_valid_d    = o_valid_q;
    grant_d      = grant_q;
    beat_d       = beat_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    burst_d      = burst_q;
    lock_d       = lock_q;

    if (noc_xfer) begin
      o_valid_d = 1'b0;
      beat_d    = beat_q + 32'd1;
    end

    if (lock_q && !valid[owner_q]) begin
      lock_d  = 1'b0;
      burst_d = '0;
    end

    if (src_xfer) begin
      o_data_d     = src_data[winner];
      o_dest_d     = src_dest[winner];
      o_vc_d       = src_vc[winner];
      o_valid_d    = 1'b1;
      grant_d      = winner;
      last_grant_d = winner;
      if (locked_win) begin
        burst_d = burst_q + BURST_W'(1);
      end else begin
        owner_d = winner;
        burst_d = BURST_W'(1);
        lock_d  = 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data_q     <= '0;
      o_dest_q     <= '0;
      o_vc_q       <= '0;
      o_valid_q    <= 1'b0;
      grant_q      <= '0;
      beat_q       <= '0;
      last_grant_q <= REQ_IDX_WIDTH'(NUM_REQ - 1);
      owner_q      <= '0;
      burst_q      <= '0;
      lock_q       <= 1'b0;
    end else begin
      o_data_q     <= o_data_d;
      o_dest_q     <= o_dest_d;
      o_vc_q       <= o_vc_d;
      o_valid_q    <= o_valid_d;
      grant_q      <= grant_d;
      beat_q       <= beat_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      burst_q      <= burst_d;
      lock_q       <= lock_d;
    end
  end

  assign bus.req_ready_out  = req_ready_c;
  assign bus.o_data_out     = o_data_q;
  assign bus.o_dest_out     = o_dest_q;
  assign bus.o_vc_out       = o_vc_q;
  assign bus.o_valid_out    = o_valid_q;
  assign bus.o_grant_id_out = grant_q;
  assign bus.beat_count_out = beat_q;
endmodule
